// File: rtl/sorted_serializer.sv
// Ping-pong serializer: captures a sorted parallel vector into one of two
// buffers and streams it out one element per handshake, ascending or descending.
module sorted_serializer #(
  parameter int DATA_WIDTH = 16,
  parameter int DATA_NUM   = 16,
  parameter int DESCEND    = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  input  logic [DATA_WIDTH-1:0]       in_data [DATA_NUM],
  output logic                        in_ready,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [$clog2(DATA_NUM)-1:0] out_index,
  output logic                        out_last
);

  localparam int IDX_W = $clog2(DATA_NUM);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DATA_NUM - 1);

  logic [DATA_WIDTH-1:0] mem [2][DATA_NUM];
  logic [1:0]            full;
  logic                  wp;
  logic                  rp;
  logic [IDX_W-1:0]      cnt;
  logic                  capture;
  logic                  xfer;
  logic                  retire;

  // Handshake flags come straight from registered state, never from the inputs.
  assign in_ready  = !full[wp];
  assign out_valid = full[rp];
  assign out_index = (DESCEND != 0) ? (LAST - cnt) : cnt;
  assign out_data  = mem[rp][out_index];
  assign out_last  = out_valid && (cnt == LAST);

  assign capture = in_valid && in_ready;
  assign xfer    = out_valid && out_ready;
  assign retire  = xfer && out_last;

  // Control state. A capture and a retire can never target the same buffer:
  // capture needs it empty, retire needs it full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full <= '0;
      wp   <= 1'b0;
      rp   <= 1'b0;
      cnt  <= '0;
    end else begin
      if (capture) begin
        full[wp] <= 1'b1;
        wp       <= ~wp;
      end
      if (retire) begin
        full[rp] <= 1'b0;
        rp       <= ~rp;
        cnt      <= '0;
      end else if (xfer) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Vector storage; only an empty buffer is ever written.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < DATA_NUM; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else if (capture) begin
      for (int k = 0; k < DATA_NUM; k++) begin
        mem[wp][k] <= in_data[k];
      end
    end
  end

endmodule

// File: tb/tb_sorted_serializer.sv
// Directed bench for sorted_serializer: ascending and descending instances
// driven in lockstep and compared against a small occupancy/stream model.
module tb_sorted_serializer;

  localparam int W = 16;
  localparam int N = 16;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [W-1:0] in_data [N];
  logic         ir0, ov0, ol0, ir1, ov1, ol1;
  logic [W-1:0] od0, od1;
  logic [3:0]   oi0, oi1;

  int total = 0;
  int bad   = 0;

  int occ  = 0;
  int mcnt = 0;
  int ncap = 0;
  logic [N*W-1:0] vq [$];

  always #5 clk = ~clk;

  sorted_serializer #(.DATA_WIDTH(W), .DATA_NUM(N), .DESCEND(0)) dut_asc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir0), .out_valid(ov0), .out_ready(out_ready),
    .out_data(od0), .out_index(oi0), .out_last(ol0)
  );

  sorted_serializer #(.DATA_WIDTH(W), .DATA_NUM(N), .DESCEND(1)) dut_desc (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir1), .out_valid(ov1), .out_ready(out_ready),
    .out_data(od1), .out_index(oi1), .out_last(ol1)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] pack();
    logic [N*W-1:0] p;
    for (int k = 0; k < N; k++) p[k*W +: W] = in_data[k];
    return p;
  endfunction

  task automatic rand_vec();
    for (int k = 0; k < N; k++) in_data[k] = W'($urandom);
  endtask

  // Called at a falling edge with inputs already set: checks outputs, advances
  // the model by the coming rising edge, then waits for the next falling edge.
  task automatic cyc();
    logic ev, er, cap, rel;
    logic [N*W-1:0] v;
    ev = (occ > 0);
    er = (occ < 2);
    chk1("in_ready_asc", ir0, er);
    chk1("in_ready_desc", ir1, er);
    chk1("out_valid_asc", ov0, ev);
    chk1("out_valid_desc", ov1, ev);
    if (ev) begin
      v = vq[0];
      chk("data_asc", int'(od0), int'(v[mcnt*W +: W]));
      chk("index_asc", int'(oi0), mcnt);
      chk1("last_asc", ol0, mcnt == N-1);
      chk("data_desc", int'(od1), int'(v[(N-1-mcnt)*W +: W]));
      chk("index_desc", int'(oi1), N-1-mcnt);
      chk1("last_desc", ol1, mcnt == N-1);
    end else begin
      chk1("last_idle", ol0, 1'b0);
    end
    cap = in_valid && er;
    rel = ev && out_ready && (mcnt == N-1);
    if (ev && out_ready) mcnt = rel ? 0 : mcnt + 1;
    if (rel) vq.delete(0);
    if (cap) begin
      vq.push_back(pack());
      ncap++;
    end
    occ = occ + (cap ? 1 : 0) - (rel ? 1 : 0);
    @(negedge clk);
  endtask

  initial begin
    int guard;
    int cap_start;
    for (int k = 0; k < N; k++) in_data[k] = '0;

    // reset state
    repeat (2) @(negedge clk);
    chk1("rst_in_ready", ir0, 1'b1);
    chk1("rst_out_valid", ov0, 1'b0);
    chk1("rst_out_last", ol0, 1'b0);
    chk("rst_index_asc", int'(oi0), 0);
    chk("rst_index_desc", int'(oi1), 15);
    chk("rst_data_asc", int'(od0), 0);
    chk("rst_data_desc", int'(od1), 0);
    reset = 1'b1;

    // single vector k*3, both orders
    for (int k = 0; k < N; k++) in_data[k] = W'(k * 3);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      chk("vec3_asc", int'(od0), i * 3);
      chk("vec3_desc", int'(od1), (15 - i) * 3);
      chk1("vec3_last", ol0, i == 15);
      cyc();
    end
    chk1("vec3_idle", ov0, 1'b0);
    cyc();

    // three vectors offered with the output stalled
    out_ready = 1'b0;
    for (int v = 1; v <= 3; v++) begin
      for (int k = 0; k < N; k++) in_data[k] = W'(v * 256 + k);
      in_valid = 1'b1;
      cyc();
    end
    repeat (3) cyc();
    chk1("held_ready_low", ir0, 1'b0);
    chk("held_data", int'(od0), 256);
    out_ready = 1'b1;
    repeat (15) cyc();
    chk1("last_ready_low", ir0, 1'b0);
    chk1("last_flag", ol0, 1'b1);
    cyc();
    chk1("ready_rise", ir0, 1'b1);
    chk("second_vec_first", int'(od0), 512);
    cyc();
    in_valid = 1'b0;
    repeat (34) cyc();

    // continuous streaming, no bubbles
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 80; i++) begin
      rand_vec();
      cyc();
      chk1("no_bubble", ov0, 1'b1);
      chk1("last_period", ol0, (i % 16) == 15);
    end
    in_valid = 1'b0;
    repeat (40) cyc();

    // 100 random vectors with random backpressure
    cap_start = ncap;
    guard = 0;
    while (((ncap - cap_start) < 100 || occ > 0) && guard < 10000) begin
      in_valid = ((ncap - cap_start) < 100);
      rand_vec();
      out_ready = 1'($urandom_range(0, 1));
      cyc();
      guard++;
    end
    chk1("random_complete", guard < 10000, 1'b1);
    chk("random_count", ncap - cap_start, 100);

    // reset in the middle of a vector with both buffers full
    in_valid = 1'b1;
    out_ready = 1'b0;
    rand_vec();
    cyc();
    rand_vec();
    cyc();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (7) cyc();
    out_ready = 1'b0;
    cyc();
    chk("mid_cnt7", int'(oi0), 7);
    chk1("mid_both_full", ir0, 1'b0);
    #2 reset = 1'b0;
    #1;
    chk1("async_out_valid", ov0, 1'b0);
    chk1("async_in_ready", ir0, 1'b1);
    chk1("async_out_last", ol0, 1'b0);
    chk("async_index_desc", int'(oi1), 15);
    chk("async_data", int'(od0), 0);
    occ = 0;
    mcnt = 0;
    vq.delete();
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < N; k++) in_data[k] = W'(500 + k);
    in_valid = 1'b1;
    out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    chk("post_reset_first", int'(od0), 500);
    repeat (20) cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sorted_serializer.md
SORTED_SERIALIZER -- requirements
Module: sorted_serializer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, bit width of each element.
REQ-002 SHALL have parameter DATA_NUM, default 16, elements per vector; legal range 2..256.
REQ-003 SHALL have parameter DESCEND, default 0; 0 emits element index 0 first, 1 emits index DATA_NUM-1 first.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  one clock; reset is asynchronous and active-low.
REQ-006 SHALL have port in_valid  input  1  in_data holds a vector to capture.
REQ-007 SHALL have port in_data  input  DATA_WIDTH x DATA_NUM (unpacked)  sorted parallel vector from the pixel sorter.
REQ-008 SHALL have port in_ready  output  1  a ping-pong buffer is free.
REQ-009 SHALL have port out_valid  output  1  out_data holds a valid element.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the element.
REQ-011 SHALL have port out_data  output  DATA_WIDTH  current element.
REQ-012 SHALL have port out_index  output  $clog2(DATA_NUM)  element index of out_data in the source vector.
REQ-013 SHALL have port out_last  output  1  out_data is the final element of its vector.

Function
REQ-014 SHALL hold two vector buffers (B0, B1), each with a FULL flag, plus a write pointer wp and a read pointer rp, both initially B0.
REQ-015 SHALL capture in_data into buffer wp on a rising edge where in_valid && in_ready, set that buffer FULL, and toggle wp.
REQ-016 SHALL drive in_ready = !FULL[wp], from registered state only; no combinational path from out_ready or in_valid.
REQ-017 SHALL drive out_valid = FULL[rp], from registered state only; first element appears the cycle after capture (1-cycle latency).
REQ-018 SHALL use element counter cnt (0..DATA_NUM-1); out_index = cnt when DESCEND=0, DATA_NUM-1-cnt when DESCEND=1; out_data = buffer[rp][out_index].
REQ-019 SHALL assert out_last when out_valid && cnt == DATA_NUM-1.
REQ-020 SHALL, on out_valid && out_ready with cnt < DATA_NUM-1, increment cnt.
REQ-021 SHALL, on out_valid && out_ready with out_last, clear FULL[rp], toggle rp, and set cnt to 0.
REQ-022 SHALL hold out_data, out_index, out_last stable while out_valid && !out_ready.
REQ-023 SHALL ignore in_data when in_valid is low or in_ready is low; a refused vector is not stored.
REQ-024 SHALL allow a capture into buffer wp and a final-element release of buffer rp in the same cycle when they are different buffers; both take effect.
REQ-025 SHALL, with both buffers FULL and the last element transferring, keep in_ready low that cycle and raise it the next cycle.
REQ-026 SHALL sustain back-to-back vectors with no bubble on out_valid when in_valid is held high and out_ready is held high.
REQ-027 SHALL never modify a FULL buffer's contents until it is released.

Reset
REQ-028 SHALL, while reset is low, asynchronously clear FULL flags, wp, rp, cnt; outputs: in_ready=1, out_valid=0, out_last=0, out_index=(DESCEND ? DATA_NUM-1 : 0), out_data=0.
REQ-029 SHALL clear buffer contents to 0 on reset.
REQ-030 SHALL, on reset asserted mid-vector, discard all buffered data; no element of a pre-reset vector is emitted after release.
REQ-031 SHALL resume normal operation on the first rising edge after reset deasserts.

Verification
REQ-032 Single vector, DATA_NUM=16, DESCEND=0, in_data[k]=k*3, out_ready=1 -> out_valid cycles 1..16 after capture, out_data 0,3,...,45, out_index 0..15, out_last only on 45.
REQ-033 Same vector with DESCEND=1 -> out_data 45,42,...,0, out_index 15..0, out_last on 0.
REQ-034 Three vectors offered back-to-back, out_ready=0 -> first two captured, in_ready low from second capture on; third held; after out_ready=1 and 16 transfers, in_ready rises one cycle after out_last, third captured.
REQ-035 Random out_ready (50%) over 100 random vectors -> output stream equals concatenation of inputs in order; data stable during stalls; no loss or duplication.
REQ-036 Reset low at cnt=7 with both buffers full -> out_valid=0 and in_ready=1 within the same cycle; after release, first emitted value comes from the first post-reset vector.
REQ-037 Continuous in_valid=1, out_ready=1 -> out_valid stays high from first element onward, out_last every 16th cycle.
